multi_cycle_control: RTL
========================

Name: multi_cycle_control

Overview:
- Multi-cycle successor to the single-cycle control path: a Moore FSM plus ALU/immediate decoders that sequence RV32I-subset instructions over several cycles.
- Supported instructions: R-type add/sub/slt/or/and, addi, lw, sw, beq, bne, jal.
- Drives the multi-cycle datapath: shared instruction/data memory, IR, OldPC, A/B, ALUOut and Data registers.
- Adds a memory-ready wait handshake, bne support and an illegal-instruction trap state.

Parameters:
- ALU_OP_W, 3, width of o_alu_op. Must be >= 3; codes are zero-extended.
- IMM_CTL_W, 2, width of o_imm_ctl. Must be >= 2; codes are zero-extended.
- EN_BNE, 1, when 1, branch f3=001 is bne; when 0, f3=001 traps.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_opcode  in  7  IR[6:0]; sampled in DECODE.
- i_f3  in  3  IR[14:12].
- i_f7_bit6  in  1  IR[30].
- i_zero  in  1  ALU zero flag.
- i_mem_ready  in  1  memory access completes this cycle.
- o_pc_wr  out  1  PC write enable.
- o_adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- o_mem_wr  out  1  memory write strobe.
- o_ir_wr  out  1  IR and OldPC write enable.
- o_res_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALU result.
- o_alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A.
- o_alu_src_b  out  2  ALU B select: 00 = B, 01 = Imm, 10 = const 4.
- o_alu_op  out  ALU_OP_W  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- o_imm_ctl  out  IMM_CTL_W  immediate format: 00 I, 01 S, 10 B, 11 J.
- o_reg_wr  out  1  register file write enable.
- o_illegal  out  1  high while in TRAP.
- o_state  out  4  current state code, for debug.

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 15. Codes 11-14 are unreachable; if entered, go to TRAP.
- Reset: asynchronous, sets state to FETCH. While i_rst_n=0, o_pc_wr, o_ir_wr, o_mem_wr and o_reg_wr are forced to 0; other outputs show FETCH values. Reset mid-instruction abandons it; no write strobe is issued afterwards.
- Outputs are decoded combinationally from state, i_f3, i_f7_bit6, i_zero and i_mem_ready. Unlisted outputs are 0.
- FETCH: adr_src=0, a=00, b=10, alu_op=add, res_src=10. ir_wr and pc_wr equal i_mem_ready. Stays in FETCH while i_mem_ready=0, else goes to DECODE.
- DECODE: a=01, b=01, imm_ctl=B, alu_op=add (branch target into ALUOut). Next state by opcode:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> TRAP
- MEMADR: a=10, b=01, alu_op=add, imm_ctl=I for lw and S for sw. Goes to MEMREAD for lw, MEMWRITE for sw. Opcode is held stable by IR.
- MEMREAD: adr_src=1. Waits for i_mem_ready, then goes to MEMWB.
- MEMWB: res_src=01, reg_wr=1, then FETCH.
- MEMWRITE: adr_src=1, mem_wr=1 held until the cycle with i_mem_ready=1, then FETCH.
- EXECR: a=10, b=00. ALU op from f3:
  - 000: sub if f7_bit6=1, else add
  - 010: slt
  - 110: or
  - 111: and
  - Next state ALUWB; any other f3 -> TRAP (no writeback).
- EXECI: a=10, b=01, imm_ctl=I. Same f3 map except 000 is always add (f7_bit6 ignored). Next state ALUWB; unsupported f3 -> TRAP.
- ALUWB: res_src=00, reg_wr=1, then FETCH.
- BRANCH: a=10, b=00, alu_op=sub, res_src=00.
  - f3=000: pc_wr=i_zero.
  - f3=001 with EN_BNE=1: pc_wr=!i_zero.
  - other f3: no pc_wr, go to TRAP.
  - Otherwise next state FETCH.
- JAL: a=01, b=10, alu_op=add, res_src=00, pc_wr=1 (PC <= ALUOut target), then ALUWB (rd <= OldPC+4).
- TRAP: o_illegal=1, no strobes. Sticky until reset.
- Cycle counts with i_mem_ready always 1:
  - branch: 3
  - R-type, addi, sw, jal: 4
  - lw: 5
  - Each wait cycle adds one.

Test Plan:
- Reset then R-type: opcode 0110011, f3=000, f7_bit6=1, ready=1 -> states 0,1,6,8,0. In EXECR alu_op=001; reg_wr=1 only in ALUWB.
- lw with waits: opcode 0000011, ready=0 for 2 cycles in FETCH and 1 in MEMREAD -> FETCH held 3 cycles with ir_wr=0 until ready. Sequence 0,1,2,3,4; MEMWB has res_src=01, reg_wr=1. Total 8 cycles.
- sw: opcode 0100011, ready=0 for 1 cycle in MEMWRITE -> mem_wr=1 for 2 cycles, adr_src=1, imm_ctl=01 in MEMADR, then FETCH.
- Branches: beq with zero=0 -> pc_wr=0; beq with zero=1 -> pc_wr=1. bne (f3=001) with zero=0 -> pc_wr=1. Each takes 3 cycles.
- jal then addi: jal -> JAL pc_wr=1, ALUWB reg_wr=1. addi f3=000, f7_bit6=1 -> alu_op=000 (add).
- Illegal cases: opcode 1111111 -> TRAP (15), o_illegal=1, no strobes for 10 cycles. Then assert i_rst_n=0 mid-MEMWRITE -> mem_wr drops immediately and state=0.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the multi-cycle RV32I-subset datapath; outputs decode combinationally from state.
// Three to five cycles per instruction; FETCH, MEMREAD and MEMWRITE stall until i_mem_ready.
module multi_cycle_control #(
  parameter int ALU_OP_W  = 3,
  parameter int IMM_CTL_W = 2,
  parameter bit EN_BNE    = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_f3,
  input  logic                 i_f7_bit6,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_pc_wr,
  output logic                 o_adr_src,
  output logic                 o_mem_wr,
  output logic                 o_ir_wr,
  output logic [1:0]           o_res_src,
  output logic [1:0]           o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [ALU_OP_W-1:0]  o_alu_op,
  output logic [IMM_CTL_W-1:0] o_imm_ctl,
  output logic                 o_reg_wr,
  output logic                 o_illegal,
  output logic [3:0]           o_state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd15
  } state_t;

  localparam logic [ALU_OP_W-1:0]  ALU_ADD = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0]  ALU_SUB = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0]  ALU_AND = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0]  ALU_OR  = ALU_OP_W'(3'b011);
  localparam logic [ALU_OP_W-1:0]  ALU_SLT = ALU_OP_W'(3'b101);
  localparam logic [IMM_CTL_W-1:0] IMM_I   = IMM_CTL_W'(2'b00);
  localparam logic [IMM_CTL_W-1:0] IMM_S   = IMM_CTL_W'(2'b01);
  localparam logic [IMM_CTL_W-1:0] IMM_B   = IMM_CTL_W'(2'b10);

  state_t state, state_nxt;
  logic   pc_wr, mem_wr, ir_wr, reg_wr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_wr       = 1'b0;
    mem_wr      = 1'b0;
    ir_wr       = 1'b0;
    reg_wr      = 1'b0;
    o_adr_src   = 1'b0;
    o_res_src   = 2'b00;
    o_alu_src_a = 2'b00;
    o_alu_src_b = 2'b00;
    o_alu_op    = ALU_ADD;
    o_imm_ctl   = IMM_I;
    o_illegal   = 1'b0;
    case (state)
      FETCH: begin
        o_alu_src_b = 2'b10;
        o_res_src   = 2'b10;
        ir_wr       = i_mem_ready;
        pc_wr       = i_mem_ready;
        if (i_mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        o_imm_ctl   = IMM_B;
        case (i_opcode)
          7'b0000011, 7'b0100011: state_nxt = MEMADR;
          7'b0110011:             state_nxt = EXECR;
          7'b0010011:             state_nxt = EXECI;
          7'b1100011:             state_nxt = BRANCH;
          7'b1101111:             state_nxt = JAL;
          default:                state_nxt = TRAP;
        endcase
      end
      MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        // Only lw and sw reach here; opcode bit 5 tells them apart.
        o_imm_ctl   = i_opcode[5] ? IMM_S : IMM_I;
        state_nxt   = i_opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        o_adr_src = 1'b1;
        if (i_mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        o_res_src = 2'b01;
        reg_wr    = 1'b1;
        state_nxt = FETCH;
      end
      MEMWRITE: begin
        o_adr_src = 1'b1;
        mem_wr    = 1'b1;
        if (i_mem_ready) state_nxt = FETCH;
      end
      EXECR, EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = (state == EXECI) ? 2'b01 : 2'b00;
        state_nxt   = ALUWB;
        case (i_f3)
          3'b000:  o_alu_op = (state == EXECR && i_f7_bit6) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_op = ALU_SLT;
          3'b110:  o_alu_op = ALU_OR;
          3'b111:  o_alu_op = ALU_AND;
          default: state_nxt = TRAP;
        endcase
      end
      ALUWB: begin
        reg_wr    = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = ALU_SUB;
        state_nxt   = FETCH;
        if (i_f3 == 3'b000)                pc_wr = i_zero;
        else if (i_f3 == 3'b001 && EN_BNE) pc_wr = !i_zero;
        else                               state_nxt = TRAP;
      end
      JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        pc_wr       = 1'b1;
        state_nxt   = ALUWB;
      end
      TRAP: begin
        o_illegal = 1'b1;
      end
      default: state_nxt = TRAP;
    endcase
  end

  // Strobes are gated by reset so an abandoned instruction never writes.
  assign o_pc_wr  = pc_wr  & i_rst_n;
  assign o_mem_wr = mem_wr & i_rst_n;
  assign o_ir_wr  = ir_wr  & i_rst_n;
  assign o_reg_wr = reg_wr & i_rst_n;
  assign o_state  = state;

endmodule
